// File: rtl/lsd_pkg.sv
// Shared loop-stream definitions: branch opcode, B-immediate decode, resolver states.
// Also used by stream_loop_detector, so keep it free of resolver-only parameters.
package lsd_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        RECOVER = 2'd2
    } lsd_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pred_target;
    } br_entry_t;

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic is_branch_op(input logic [31:0] inst);
        return inst[6:0] == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/loop_branch_resolver_if.sv
// Stream-side, EX-side and redirect signals of the loop branch resolver.
// master drives stream/EX inputs and observes results; slave is the resolver.
interface loop_branch_resolver_if #(
    parameter int CNT_W = 16
);
    logic             reuse_signal;
    logic [31:0]      out_instruction;
    logic [31:0]      stream_pc;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             mispredict;
    logic [31:0]      recovery_pc;
    logic [CNT_W-1:0] iter_count;
    logic             overflow_err;
    logic             q_empty;

    modport master (
        output reuse_signal, out_instruction, stream_pc,
        output ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
        input  mispredict, recovery_pc, iter_count, overflow_err, q_empty
    );

    modport slave (
        input  reuse_signal, out_instruction, stream_pc,
        input  ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
        output mispredict, recovery_pc, iter_count, overflow_err, q_empty
    );
endinterface

// File: rtl/lsd_branch_fifo.sv
// In-flight branch queue; push visible at head one cycle later, head is combinational.
// No backpressure: a push into a full queue without a same-cycle pop is dropped and flagged.
module lsd_branch_fifo
    import lsd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  br_entry_t push_dat,
    input  logic      pop,
    input  logic      clear,
    output br_entry_t head,
    output logic      full,
    output logic      empty,
    output logic      drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    br_entry_t   mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full queue can still accept.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/loop_branch_resolver.sv
// Checks streamed loop branches against EX outcomes; mispredict/recovery_pc one cycle after compare.
// No backpressure: pushes are dropped when the queue is full, recovery flushes everything.
module loop_branch_resolver
    import lsd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    loop_branch_resolver_if.slave lbr
);
    lsd_state_e       state_q, state_d;
    logic             mispredict_q, mispredict_d;
    logic [31:0]      rpc_q, rpc_d;
    logic [CNT_W-1:0] iter_q;
    logic             ovf_q;

    logic             push_req;
    logic             pop_req;
    logic             clear;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;
    br_entry_t        push_dat;
    br_entry_t        head;
    logic             pc_match;
    logic             pred_hit;

    assign push_req = lbr.reuse_signal && is_branch_op(lbr.out_instruction) && (state_q != RECOVER);
    assign push_dat = '{pc: lbr.stream_pc, pred_target: lbr.stream_pc + b_imm(lbr.out_instruction)};
    assign pop_req  = lbr.ex_valid && lbr.ex_is_branch && !fifo_empty && (state_q == TRACK);
    assign clear    = (state_q == RECOVER);
    assign pc_match = (head.pc == lbr.ex_pc);
    assign pred_hit = pc_match && lbr.ex_taken && (lbr.ex_target == head.pred_target);

    lsd_branch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_req),
        .push_dat (push_dat),
        .pop      (pop_req),
        .clear    (clear),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    always_comb begin
        state_d      = state_q;
        mispredict_d = 1'b0;
        rpc_d        = rpc_q;
        unique case (state_q)
            IDLE: begin
                if (push_req) state_d = TRACK;
            end
            TRACK: begin
                if (pop_req && !pred_hit) begin
                    // Exit, wrong target and desync all redirect to the architecturally correct path.
                    state_d      = RECOVER;
                    mispredict_d = 1'b1;
                    rpc_d        = lbr.ex_taken ? lbr.ex_target : lbr.ex_pc + 32'd4;
                end else if (fifo_empty && !lbr.reuse_signal) begin
                    state_d = IDLE;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mispredict_q <= 1'b0;
            rpc_q        <= '0;
            iter_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mispredict_q <= mispredict_d;
            rpc_q        <= rpc_d;
            if (fifo_drop) ovf_q <= 1'b1;
            if (state_q == RECOVER) begin
                iter_q <= '0;
            end else if (pop_req && pred_hit && (iter_q != {CNT_W{1'b1}})) begin
                iter_q <= iter_q + 1'b1;
            end
        end
    end

    assign lbr.mispredict   = mispredict_q;
    assign lbr.recovery_pc  = rpc_q;
    assign lbr.iter_count   = iter_q;
    assign lbr.overflow_err = ovf_q;
    assign lbr.q_empty      = fifo_empty;

endmodule

// File: tb/tb_loop_branch_resolver.sv
// Scoreboard bench: a reference queue model predicts iteration count, occupancy, overflow and redirects.
module tb_loop_branch_resolver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    loop_branch_resolver_if #(.CNT_W(16)) bus ();

    loop_branch_resolver #(.DEPTH(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .lbr   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pred;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] exp_q[$];
    int          m_iter = 0;
    logic        m_ovf = 1'b0;
    bit          m_recover = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_model(input string tag);
        check({tag, "/iter"},     32'(bus.iter_count),   32'(m_iter));
        check({tag, "/q_empty"},  32'(bus.q_empty),      32'(mq.size() == 0));
        check({tag, "/overflow"}, 32'(bus.overflow_err), 32'(m_ovf));
    endtask

    // Drives one cycle of stimulus and advances the reference model by the same cycle.
    task automatic step(input logic reuse, input logic [31:0] inst, input logic [31:0] spc,
                        input logic [31:0] pred, input logic exv, input logic [31:0] epc,
                        input logic tk, input logic [31:0] tgt);
        bit   nxt_rec = 1'b0;
        ent_t e;
        bus.reuse_signal    = reuse;
        bus.out_instruction = inst;
        bus.stream_pc       = spc;
        bus.ex_valid        = exv;
        bus.ex_is_branch    = exv;
        bus.ex_pc           = epc;
        bus.ex_taken        = tk;
        bus.ex_target       = tgt;
        if (m_recover) begin
            mq.delete();
            m_iter = 0;
        end else begin
            if (exv && mq.size() > 0) begin
                if (mq[0].pc == epc && tk && mq[0].pred == tgt) begin
                    if (m_iter < 65535) m_iter++;
                end else begin
                    exp_q.push_back(tk ? tgt : epc + 32'd4);
                    nxt_rec = 1'b1;
                end
                void'(mq.pop_front());
            end
            if (reuse && inst[6:0] == 7'b1100011) begin
                if (mq.size() < 4) begin
                    e.pc   = spc;
                    e.pred = pred;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_recover = nxt_rec;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] pred);
        step(1'b1, inst, pc, pred, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic ex(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        step(1'b0, 32'h0000_0013, 32'd0, 32'd0, 1'b1, pc, tk, tgt);
    endtask

    task automatic idle();
        step(1'b0, 32'h0000_0013, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.mispredict) begin
            if (exp_q.size() == 0) check("spurious_mispredict", 32'(bus.mispredict), 32'd0);
            else check("recovery_pc", bus.recovery_pc, exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        bus.reuse_signal = 1'b0; bus.out_instruction = '0; bus.stream_pc = '0;
        bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_pc = '0;
        bus.ex_taken = 1'b0; bus.ex_target = '0;
        #2;
        check("rst/mispredict",  32'(bus.mispredict),   32'd0);
        check("rst/recovery_pc", bus.recovery_pc,       32'd0);
        check("rst/iter",        32'(bus.iter_count),   32'd0);
        check("rst/overflow",    32'(bus.overflow_err), 32'd0);
        check("rst/q_empty",     32'(bus.q_empty),      32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Non-branch opcode while streaming is not queued
        step(1'b1, 32'h0000_0013, 32'h100, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_model("nop");

        // Two correct iterations
        push(32'h10C, 32'hFE00_0AE3, 32'h100);
        push(32'h10C, 32'hFE00_0AE3, 32'h100);
        check_model("two_pushed");
        ex(32'h10C, 1'b1, 32'h100);
        ex(32'h10C, 1'b1, 32'h100);
        idle();
        check_model("two_iter");
        check("two_iter/const", 32'(bus.iter_count), 32'd2);

        // Loop exit after one more correct pop
        push(32'h10C, 32'hFE00_0AE3, 32'h100);
        push(32'h10C, 32'hFE00_0AE3, 32'h100);
        ex(32'h10C, 1'b1, 32'h100);
        check_model("exit_pre");
        ex(32'h10C, 1'b0, 32'd0);
        idle();
        check("exit/mispredict_one_cycle", 32'(bus.mispredict), 32'd0);
        check("exit/recovery_pc_held", bus.recovery_pc, 32'h110);
        check_model("exit_post");

        // Desync: EX branch PC differs from queue head
        push(32'h10C, 32'hFE00_0AE3, 32'h100);
        ex(32'h200, 1'b1, 32'h300);
        idle();
        check_model("desync");

        // Taken with a target other than the predicted one
        push(32'h10C, 32'hFE00_0AE3, 32'h100);
        ex(32'h10C, 1'b1, 32'h104);
        idle();
        check_model("bad_target");

        // Overflow: five pushes into four slots, survivors drain in order
        for (int i = 0; i < 5; i++) push(32'h400 + 32'(4 * i), 32'h0000_0463, 32'h408 + 32'(4 * i));
        check_model("overflow");
        for (int i = 0; i < 4; i++) ex(32'h400 + 32'(4 * i), 1'b1, 32'h408 + 32'(4 * i));
        idle();
        check_model("ovf_drain");

        // Branch in EX with an empty queue is ignored
        ex(32'h410, 1'b1, 32'h418);
        check_model("untracked");

        // Reset mid-stream clears everything immediately
        push(32'h600, 32'h0000_0463, 32'h608);
        push(32'h604, 32'h0000_0463, 32'h60C);
        reset = 1'b1;
        #1;
        mq.delete(); m_iter = 0; m_ovf = 1'b0; m_recover = 1'b0;
        check("midrst/mispredict", 32'(bus.mispredict), 32'd0);
        check_model("midrst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Full queue with simultaneous push and pop, order kept across pointer wrap
        for (int i = 0; i < 4; i++) push(32'h500 + 32'(4 * i), 32'hFE00_08E3, 32'h4F0 + 32'(4 * i));
        check_model("full");
        step(1'b1, 32'hFE00_08E3, 32'h510, 32'h500, 1'b1, 32'h500, 1'b1, 32'h4F0);
        check_model("full_push_pop");
        for (int i = 1; i < 5; i++) ex(32'h500 + 32'(4 * i), 1'b1, 32'h4F0 + 32'(4 * i));
        idle();
        check_model("wrap_drain");

        idle();
        check("pending_mispredicts", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/loop_branch_resolver.md
# loop_branch_resolver

Execute-side companion to `stream_loop_detector`. While the detector replays a captured loop body and asserts `reuse_signal`, it predicts every streamed backward branch as taken. This block records each streamed branch in an in-flight queue. When the branch reaches EX, the block checks the actual outcome against that prediction. On loop exit, or on any queue desynchronisation, it raises the registered `mispredict` pulse and a recovery PC that feed the detector's `mispredict` input and the fetch PC mux.

## Interface
- `DEPTH`, 4: number of in-flight queue entries, which covers IF-to-EX distance plus slack; must be a power of two, ≥2.
- `CNT_W`, 16: width of the saturating iteration counter.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears queue, state and all outputs.
- `reuse_signal`  in  1  detector is streaming; enables pushes.
- `out_instruction`  in  32  streamed instruction from the detector.
- `stream_pc`  in  32  PC associated with `out_instruction`.
- `ex_valid`  in  1  EX stage holds a valid instruction this cycle.
- `ex_is_branch`  in  1  EX instruction is a conditional branch.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_taken`  in  1  resolved branch outcome.
- `ex_target`  in  32  resolved taken target.
- `mispredict`  out  1  one-cycle registered pulse.
- `recovery_pc`  out  32  redirect PC, valid while `mispredict`=1 and held afterwards.
- `iter_count`  out  CNT_W  correctly predicted loop branches since last recovery, saturating.
- `overflow_err`  out  1  sticky; a push was dropped because the queue was full.
- `q_empty`  out  1  queue empty.

## Operation
- **Push condition:** `reuse_signal` & (`out_instruction[6:0]`==7'b1100011) & state≠RECOVER.
- **Entry contents:** {`stream_pc`, `pred_target`}, where `pred_target` = `stream_pc` + sign-extended B-immediate {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}. All arithmetic is 32-bit modulo 2^32.
- **Pop condition:** `ex_valid` & `ex_is_branch` & !`q_empty` & state=TRACK.
- **Outcome of a pop:**
  - Head PC == `ex_pc`, `ex_taken`=1 and `ex_target`==head `pred_target`: correct prediction. `iter_count` increments, saturating at all-ones.
  - Head PC == `ex_pc`, `ex_taken`=0: loop exit. Go to RECOVER with `recovery_pc` = `ex_pc`+4.
  - Head PC == `ex_pc`, `ex_taken`=1 but `ex_target`≠`pred_target`: go to RECOVER with `recovery_pc` = `ex_target`.
  - Head PC ≠ `ex_pc`: desync. Go to RECOVER with `recovery_pc` = `ex_taken` ? `ex_target` : `ex_pc`+4.
- A branch in EX while the queue is empty is not tracked. No pop, no action.
- **States:**
  - IDLE: queue empty, no streaming. Go to TRACK on the first push.
  - TRACK: pushes and pops are active. Go to IDLE when the queue becomes empty and `reuse_signal`=0. Go to RECOVER on any mismatch.
  - RECOVER: lasts exactly one cycle. `mispredict`=1, the queue is cleared (both pointers to 0), pushes are ignored and `iter_count` is cleared to 0. Then go to IDLE.
- **Simultaneous push and pop in one cycle:** both take effect and the occupancy is unchanged. This holds when the queue is full too, because the pop frees the slot first.
- **Push while full without a pop:** the entry is dropped and `overflow_err` is set. The queue is otherwise unaffected.
- **Pointer wrap:** pointers are `$clog2(DEPTH)`+1 bits. Full is equal indices with differing MSBs; empty is pointers equal.

## Timing
- **Reset values:** `mispredict`=0, `recovery_pc`=0, `iter_count`=0, `overflow_err`=0, `q_empty`=1, state=IDLE.
- **Latency:** the EX compare is evaluated in cycle N. `mispredict` and `recovery_pc` are registered and visible in cycle N+1 for exactly one cycle.
- A push in cycle N is poppable from cycle N+1. A same-cycle push-to-pop bypass is not supported.
- **Reset mid-operation:** asserting `reset` immediately clears all state, including a RECOVER in progress. No `mispredict` is emitted.
- `ex_*` inputs in the RECOVER cycle are ignored. The wrong-path instruction is flushed by the pipeline.

## Structure
- **Shared package `lsd_pkg`:** `OPC_BRANCH`=7'b1100011, the B-immediate extraction function, and the state enum {IDLE, TRACK, RECOVER}. `stream_loop_detector` reuses the package.
- **One sub-module, `lsd_branch_fifo`:** DEPTH×64-bit synchronous FIFO with push, pop, clear, full, empty and head outputs.

## Test plan
- **Reset:** assert `reset` mid-stream → all outputs at reset values in the same cycle; `q_empty`=1.
- **Two correct iterations:** stream PC 0x10C, instr 0xFE000AE3 (pred_target 0x100), twice. Then EX pc=0x10C, taken=1, target=0x100, twice → `iter_count`=2, no `mispredict`.
- **Loop exit:** after one correct pop, EX pc=0x10C, taken=0 → `mispredict`=1 for one cycle; `recovery_pc`=0x110; `iter_count`=0; `q_empty`=1.
- **Desync:** queue head 0x10C, EX branch pc=0x200, taken=1, target=0x300 → `mispredict`, `recovery_pc`=0x300, queue cleared.
- **Overflow:** push 5 branches with DEPTH=4 and no pops → `overflow_err`=1 sticky; the 4 entries remain and pop in order.
- **Full queue push and pop:** queue at 4 entries, push and pop in the same cycle → occupancy stays 4, no overflow, FIFO order preserved across pointer wrap.
